axi_read_slave_fsm: RTL and testbench



---
 rtl/axi_read_pkg.sv | 27 ++
 rtl/axi_addr_gen.sv | 30 +++
 rtl/axi_read_slave_fsm.sv | 139 +++++++++++++
 tb/tb_axi_read_slave_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_pkg.sv
// Shared definitions for the AXI4 read-channel responder: burst/resp codes, FSM states and the
// burst legality rule.
package axi_read_pkg;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StCapt,
    StResp
  } state_e;

  // max_size is log2 of the data bus width in bytes.
  function automatic logic burst_legal(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input logic [2:0] max_size = 3'd3);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst != 2'b11) && (size <= max_size) && ((burst != BurstWrap) || wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, arithmetic modulo 2^AW.
module axi_addr_gen
  import axi_read_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    len_i,
  input  logic [2:0]    size_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_addr_o
);

  logic [AW-1:0] bytes;
  logic [AW-1:0] total;
  logic [AW-1:0] incr;

  always_comb begin
    bytes = AW'(1) << size_i;
    total = (AW'(len_i) + AW'(1)) * bytes;
    incr  = addr_i + bytes;
    case (burst_i)
      BurstIncr: next_addr_o = incr;
      // Wrap within the total-byte aligned window containing the start address.
      BurstWrap: next_addr_o = (addr_i & ~(total - AW'(1))) | (incr & (total - AW'(1)));
      default:   next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_read_slave_fsm.sv
// AXI4 read responder: one AR burst at a time, one local read per beat, R beat every 3 cycles.
module axi_read_slave_fsm
  import axi_read_pkg::*;
#(
  parameter int unsigned IDW = 12,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic [AW-1:0]  s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [IDW-1:0] s_axi_rid,
  output logic [DW-1:0]  s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  output logic           rd_en,
  output logic [AW-1:0]  rd_addr,
  input  logic [DW-1:0]  rd_data,
  input  logic           rd_err
);

  localparam logic [2:0] MaxSize = 3'($clog2(DW / 8));

  state_e         state_q;
  logic           arready_q;
  logic [IDW-1:0] rid_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic           illegal_q;
  logic [7:0]     cnt_q;
  logic [DW-1:0]  rdata_q;
  logic [1:0]     rresp_q;
  logic           rlast_q;
  logic           rvalid_q;
  logic           rd_en_q;
  logic [AW-1:0]  rd_addr_q;
  logic [AW-1:0]  next_addr;
  logic           ar_legal;

  assign ar_legal = burst_legal(s_axi_arlen, s_axi_arsize, s_axi_arburst, MaxSize);

  axi_addr_gen #(
    .AW (AW)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      arready_q <= 1'b0;
      rid_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            rid_q     <= s_axi_arid;
            addr_q    <= s_axi_araddr;
            len_q     <= s_axi_arlen;
            size_q    <= s_axi_arsize;
            burst_q   <= s_axi_arburst;
            illegal_q <= !ar_legal;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            // rd_en/rd_addr are registered, so the ADDR-cycle strobe is set up here.
            rd_en_q   <= ar_legal;
            rd_addr_q <= s_axi_araddr;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          rd_en_q <= 1'b0;
          state_q <= StCapt;
        end
        StCapt: begin
          rdata_q  <= illegal_q ? '0 : rd_data;
          rresp_q  <= (illegal_q || rd_err) ? RespSlverr : RespOkay;
          rlast_q  <= (cnt_q == len_q);
          rvalid_q <= 1'b1;
          state_q  <= StResp;
        end
        StResp: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              state_q   <= StIdle;
            end else begin
              cnt_q     <= cnt_q + 8'd1;
              addr_q    <= next_addr;
              rd_en_q   <= !illegal_q;
              rd_addr_q <= next_addr;
              state_q   <= StAddr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;
  assign rd_en         = rd_en_q;
  assign rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_axi_read_slave_fsm.sv
// Bench for axi_read_slave_fsm: directed vector table, random bursts against a burst-level model,
// stall and mid-burst reset sequences.
module tb_axi_read_slave_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [11:0] s_axi_rid;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [63:0] rd_data;
  logic        rd_err;

  axi_read_slave_fsm #(
    .IDW (12),
    .AW  (32),
    .DW  (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_err        (rd_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  bit          force_en = 1'b0;
  logic [63:0] force_data = 64'hA5A5;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] ea_q[$];
  bit          slv_q[$];

  function automatic logic [63:0] data_fn(input logic [31:0] a);
    if (force_en) return force_data;
    return {a ^ 32'h5EED_C0DE, ~a};
  endfunction

  // Local read port: one-cycle latency; garbage on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= data_fn(rd_addr);
      rd_err  <= err_en && (rd_addr == err_addr);
    end else begin
      rd_data <= {$urandom, $urandom};
      rd_err  <= 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic bit model_legal(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    if (burst == 2'b11 || size > 3'd3) return 1'b0;
    if (burst == 2'b10) return (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
    longint unsigned a64, bytes, total, lower;
    a64   = 64'(a);
    bytes = 64'd1 << size;
    total = (64'(len) + 64'd1) * bytes;
    case (burst)
      2'b01:   return 32'(a64 + bytes);
      2'b10: begin
        lower = a64 - (a64 % total);
        return 32'(lower + ((a64 % total) + bytes) % total);
      end
      default: return a;
    endcase
  endfunction

  function automatic bit model_fill(input logic [31:0] addr, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst,
                                    input int err_beat);
    bit          legal;
    logic [31:0] a;
    legal = model_legal(len, size, burst);
    ea_q.delete();
    slv_q.delete();
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      ea_q.push_back(a);
      a = model_next(a, len, size, burst);
    end
    for (int i = 0; i <= int'(len); i++)
      slv_q.push_back(!legal || (err_beat >= 0 && ea_q[i] == ea_q[err_beat]));
    return legal;
  endfunction

  // Runs one burst, expecting addresses in ea_q and SLVERR flags in slv_q.
  task automatic run_burst(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit legal,
                           input int stall_beat, input int stall_cyc, input int err_beat,
                           input bit junk_ar);
    int          beat, cyc, nrd, waitc, stalled;
    bit          first, ar_bad, stab_bad;
    logic [78:0] snap;
    err_en = (err_beat >= 0);
    if (err_beat >= 0) err_addr = ea_q[err_beat];
    @(negedge clk);
    s_axi_arvalid = 1'b1;
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_rready  = 1'b1;
    waitc = 0;
    while (!s_axi_arready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!s_axi_arready) begin
      chk("ar_accept_timeout", 64'(s_axi_arready), 64'd1);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_axi_arvalid = junk_ar;
    s_axi_arid    = ~id;
    s_axi_araddr  = $urandom;
    beat = 0; cyc = 1; nrd = 0; stalled = 0;
    first = 1'b1; ar_bad = 1'b0; stab_bad = 1'b0; snap = '0;
    while (beat <= int'(len) && cyc < 3 * (int'(len) + 1) + stall_cyc + 10) begin
      if (s_axi_arready) ar_bad = 1'b1;
      if (rd_en) begin
        if (legal && nrd <= int'(len)) chk("rd_addr", 64'(rd_addr), 64'(ea_q[nrd]));
        nrd++;
      end
      if (s_axi_rvalid) begin
        if (first) chk("first_rvalid_cycle", 64'(cyc), 64'd3);
        first = 1'b0;
        if (beat == stall_beat && stalled < stall_cyc) begin
          if (stalled == 0) snap = {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid};
          else if (snap !== {s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}) stab_bad = 1'b1;
          stalled++;
          s_axi_rready = 1'b0;
        end else begin
          chk("rdata", s_axi_rdata, legal ? data_fn(ea_q[beat]) : 64'd0);
          chk("rresp", 64'(s_axi_rresp), slv_q[beat] ? 64'd2 : 64'd0);
          chk("rlast", 64'(s_axi_rlast), 64'(beat == int'(len)));
          chk("rid", 64'(s_axi_rid), 64'(id));
          s_axi_rready = 1'b1;
          if (beat == int'(len)) s_axi_arvalid = 1'b0;
          beat++;
        end
      end else begin
        s_axi_rready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    chk("beats_delivered", 64'(beat), 64'(int'(len) + 1));
    chk("arready_after_burst", 64'(s_axi_arready), 64'd1);
    chk("rvalid_after_burst", 64'(s_axi_rvalid), 64'd0);
    chk("rd_en_count", 64'(nrd), legal ? 64'(int'(len) + 1) : 64'd0);
    chk("arready_busy", 64'(ar_bad), 64'd0);
    chk("burst_cycles", 64'(cyc), 64'(3 * (int'(len) + 1) + 1 + stalled));
    if (stalled > 1) chk("stall_stable", 64'(stab_bad), 64'd0);
    err_en = 1'b0;
  endtask

  typedef struct {
    logic [11:0]       id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                stall_beat;
    int                stall_cyc;
    int                err_beat;
    bit                force_d;
    bit                legal;
    logic [3:0][31:0]  a;
    logic [3:0]        slv;
  } vec_t;

  vec_t        tbl[10];
  logic [11:0] r_id;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  int          r_kind, r_err, r_sb, r_sc, nrd_rst;
  bit          r_legal;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //              id      addr          len   sz    burst  stb sc  err frc leg  a[3..0]                                            slv
    tbl[0] = '{12'h5A3, 32'h40,       8'd0, 3'd3, 2'b01, -1, 0, -1, 1, 1, {32'h0, 32'h0, 32'h0, 32'h40},                       4'b0000};
    tbl[1] = '{12'h001, 32'h100,      8'd3, 3'd3, 2'b01, -1, 0, -1, 0, 1, {32'h118, 32'h110, 32'h108, 32'h100},                4'b0000};
    tbl[2] = '{12'h002, 32'h118,      8'd3, 3'd3, 2'b10, -1, 0, -1, 0, 1, {32'h110, 32'h108, 32'h100, 32'h118},                4'b0000};
    tbl[3] = '{12'h003, 32'h200,      8'd3, 3'd3, 2'b01,  1, 5,  2, 0, 1, {32'h218, 32'h210, 32'h208, 32'h200},                4'b0100};
    tbl[4] = '{12'h004, 32'h300,      8'd1, 3'd3, 2'b11, -1, 0, -1, 0, 0, {32'h0, 32'h0, 32'h0, 32'h0},                        4'b0011};
    tbl[5] = '{12'h005, 32'h44,       8'd2, 3'd2, 2'b00, -1, 0, -1, 0, 1, {32'h0, 32'h44, 32'h44, 32'h44},                     4'b0000};
    tbl[6] = '{12'h006, 32'hFFFFFFF8, 8'd1, 3'd3, 2'b01, -1, 0, -1, 0, 1, {32'h0, 32'h0, 32'h0, 32'hFFFFFFF8},                 4'b0000};
    tbl[7] = '{12'h007, 32'h80,       8'd0, 3'd4, 2'b01, -1, 0, -1, 0, 0, {32'h0, 32'h0, 32'h0, 32'h0},                        4'b0001};
    tbl[8] = '{12'h008, 32'h80,       8'd2, 3'd3, 2'b10,  0, 2, -1, 0, 0, {32'h0, 32'h0, 32'h0, 32'h0},                        4'b0111};
    tbl[9] = '{12'h009, 32'h1C,       8'd1, 3'd2, 2'b10, -1, 0, -1, 0, 1, {32'h0, 32'h0, 32'h18, 32'h1C},                      4'b0000};

    rst = 1'b1;
    s_axi_arvalid = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arsize = '0; s_axi_arburst = '0; s_axi_rready = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", 64'({s_axi_arready, s_axi_rvalid, s_axi_rlast, rd_en, s_axi_rresp}), 64'd0);
    chk("rst_rdata", s_axi_rdata, 64'd0);
    chk("rst_rid_rdaddr", 64'({s_axi_rid, rd_addr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arready_before_edge", 64'(s_axi_arready), 64'd0);
    @(negedge clk);
    chk("arready_after_edge", 64'(s_axi_arready), 64'd1);

    for (int t = 0; t < 10; t++) begin
      ea_q.delete();
      slv_q.delete();
      for (int i = 0; i <= int'(tbl[t].len); i++) begin
        ea_q.push_back(tbl[t].a[i]);
        slv_q.push_back(tbl[t].slv[i]);
      end
      force_en = tbl[t].force_d;
      run_burst(tbl[t].id, tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, tbl[t].legal,
                tbl[t].stall_beat, tbl[t].stall_cyc, tbl[t].err_beat, 1'b0);
      force_en = 1'b0;
    end

    for (int t = 0; t < 40; t++) begin
      r_kind  = int'($urandom_range(0, 9));
      r_id    = 12'($urandom);
      r_addr  = $urandom;
      r_size  = 3'($urandom_range(0, 3));
      r_len   = 8'($urandom_range(0, 7));
      r_burst = (r_kind < 5) ? 2'b01 : (r_kind < 7) ? 2'b10 : 2'b00;
      if (r_burst == 2'b10) r_len = 8'((1 << $urandom_range(1, 4)) - 1);
      if (r_kind == 0) r_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if (r_kind == 9) begin
        case ($urandom_range(0, 2))
          0: r_burst = 2'b11;
          1: r_size = 3'($urandom_range(4, 7));
          default: begin r_burst = 2'b10; r_len = 8'd2; end
        endcase
      end
      r_err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(r_len))) : -1;
      r_sb  = int'($urandom_range(0, int'(r_len)));
      r_sc  = int'($urandom_range(0, 3));
      r_legal = model_fill(r_addr, r_len, r_size, r_burst, r_err);
      run_burst(r_id, r_addr, r_len, r_size, r_burst, r_legal, r_sb, r_sc, r_err,
                1'($urandom_range(0, 1)));
    end

    // Reset during beat 2 of a 4-beat burst.
    @(negedge clk);
    s_axi_arvalid = 1'b1; s_axi_arid = 12'h7A7; s_axi_araddr = 32'h400;
    s_axi_arlen = 8'd3; s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_rready = 1'b1;
    nrd_rst = 0;
    for (int c = 0; c < 20 && nrd_rst < 2; c++) begin
      @(negedge clk);
      if (s_axi_arready) s_axi_arvalid = 1'b0;
      if (rd_en) nrd_rst++;
    end
    s_axi_arvalid = 1'b0;
    chk("rst_test_reached_beat2", 64'(nrd_rst), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctrl", 64'({s_axi_arready, s_axi_rvalid, s_axi_rlast, rd_en, s_axi_rresp}), 64'd0);
    chk("midrst_rdata", s_axi_rdata, 64'd0);
    chk("midrst_rid_rdaddr", 64'({s_axi_rid, rd_addr}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nrd_rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rd_en || s_axi_rvalid) nrd_rst++;
    end
    chk("no_beats_after_reset", 64'(nrd_rst), 64'd0);
    r_legal = model_fill(32'h500, 8'd3, 3'd3, 2'b01, -1);
    run_burst(12'h0B1, 32'h500, 8'd3, 3'd3, 2'b01, r_legal, -1, 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
